// File: rtl/y_mul_div.sv
// Iterative multiply/divide unit for MIPS mult/multu/div/divu: shift-add multiply
// and restoring divide on operand magnitudes, with sign correction in a final FIX step.
module y_mul_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] qr_q, qr_d;     // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opd_q, opd_d;   // multiplicand / divisor magnitude
  logic             is_div_q, is_div_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d, done_q, done_d;

  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   step_acc, step_qr, mag_a, mag_b, rem_fix;
  logic               sgn_a, sgn_b;

  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] qr,
                                                  input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc} + (qr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum[WIDTH:1], sum[0], qr[WIDTH-1:1]};
  endfunction

  // Remainder stays below the divisor, so bit WIDTH of the trial difference is its borrow.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] qr,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    sh    = {rem, qr[WIDTH-1]};
    trial = sh - {1'b0, dvs};
    if (!trial[WIDTH]) return {trial[WIDTH-1:0], qr[WIDTH-2:0], 1'b1};
    else               return {sh[WIDTH-1:0], qr[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    opd_d    = opd_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    sgn_a = op[0] & a[WIDTH-1];
    sgn_b = op[0] & b[WIDTH-1];
    mag_a = sgn_a ? -a : a;
    mag_b = sgn_b ? -b : b;

    step     = is_div_q ? div_step(acc_q, qr_q, opd_q) : mul_step(acc_q, qr_q, opd_q);
    step_acc = step[2*WIDTH-1:WIDTH];
    step_qr  = step[WIDTH-1:0];
    prod     = (sa_q ^ sb_q) ? -step : step;
    // With a zero divisor every trial succeeds, leaving |a| here, so this restores a.
    rem_fix  = sa_q ? -step_acc : step_acc;

    unique case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          is_div_d = op[1];
          sa_d     = sgn_a;
          sb_d     = sgn_b;
          acc_d    = '0;
          qr_d     = op[1] ? mag_a : mag_b;
          opd_d    = op[1] ? mag_b : mag_a;
          cnt_d    = CW'(WIDTH);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          qr_d  = step_qr;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(2)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
            dz_d = 1'b0;
          end else if (opd_q == '0) begin
            hi_d = rem_fix;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = (sa_q ^ sb_q) ? -step_qr : step_qr;
            dz_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      opd_q    <= opd_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: doc/y_mul_div.md
# y_mul_div

Parametrised iterative multiply/divide unit that adds the MIPS `mult`, `multu`, `div` and `divu` operations to the pipelined CPU, alongside the combinational ALU. The EX stage launches an operation with a one-cycle `start`. The unit then runs a shift-add or restoring-divide sequence for WIDTH cycles and delivers a double-width product, or a quotient and remainder, into HI/LO registers. While it runs it holds `busy` so the hazard logic can stall `mfhi`/`mflo`; a `cancel` input lets a pipeline flush abandon an in-flight operation.

## Interface
- WIDTH, 32, operand width in bits; legal values are 4 to 64, even.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only while `busy`=0.
- op  in  2  operation: 00 multu, 01 mult, 10 divu, 11 div; sampled with `start`.
- a  in  WIDTH  multiplicand or dividend; sampled with `start`.
- b  in  WIDTH  multiplier or divisor; sampled with `start`.
- cancel  in  1  synchronous abort of the current or requested operation.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse; `hi`, `lo` and `dz` are updated and valid.
- hi  out  WIDTH  high product half, or remainder.
- lo  out  WIDTH  low product half, or quotient.
- dz  out  1  last completed operation was a division by zero.

## Operation
- **States:** IDLE, RUN, FIX.
- **Outputs:** `busy`=1 in RUN and FIX. `done` is registered, never combinational.
- **Launch:** IDLE with `start`=1 and `cancel`=0 at an edge:
  - latch op, the operand signs and |a|, |b|; unsigned ops take the magnitude as-is;
  - clear the accumulator;
  - load counter = WIDTH;
  - go to RUN.
- **RUN (one step per edge):**
  - Multiply: shift-add, one multiplier bit per edge, LSB first.
  - Divide: restoring, one quotient bit per edge, MSB first.
  - Decrement the counter each edge; at counter = 1 go to FIX.
- **FIX (one edge):**
  - Mult: negate the 2·WIDTH product when sign(a)^sign(b).
  - Div: negate the quotient when sign(a)^sign(b); negate the remainder when sign(a).
  - Write `hi`/`lo`, set `done`=1, go to IDLE.
- **Results:**
  - Multiply: {hi,lo} = a·b exactly, 2·WIDTH bits. Signed ops use two's complement.
  - Divide: lo = a/b truncated toward zero; hi = a − lo·b, whose sign follows a.
- **Division by zero (b=0):**
  - lo = all ones; hi = a unmodified (signed and unsigned); dz=1.
  - No sign correction is applied to the forced values.
- **Signed overflow:** mostneg / −1 gives lo = mostneg, hi = 0, dz=0. This falls out of the magnitude algorithm wrapping in WIDTH bits and needs no special case.
- **dz updates:** only on a `done` edge; cleared on any non-div-by-zero completion.
- **Holding:** `hi`/`lo`/`dz` hold between completions. A new launch does not disturb them until its own `done`.
- **Ignored start:** `start` while `busy`=1 is ignored, not queued.
- **Cancel:**
  - `cancel`=1 at any edge in RUN/FIX returns to IDLE. No `done`; `hi`/`lo`/`dz` are unchanged.
  - `cancel` and `start` together in IDLE: cancel wins, nothing launches.
- **Reset:**
  - `rst_n`=0 forces IDLE, busy=0, done=0, hi=0, lo=0, dz=0 and clears the counter and datapath immediately, including mid-operation.
  - Operation resumes on the first rising edge after deassertion.

## Timing
- Accept edge E0. RUN occupies edges E1..E(WIDTH−1); FIX is edge E(WIDTH).
- `busy` is high from after E0 until after E(WIDTH).
- `done` is high for exactly the cycle following E(WIDTH). Latency is WIDTH edges from accept to result, identical for all ops and operands; there is no early termination.
- **Back-to-back:** `start` in the cycle where `done`=1 (busy=0) is accepted, so the issue interval is WIDTH+1 cycles.
- **Stable reads:** `hi`/`lo` change only on the FIX edge and on reset; readers may sample them any cycle `busy`=0.

## Test plan
- **Reset values:** assert rst_n=0 mid-RUN of a divu → busy, done, hi, lo, dz all 0 immediately. Release, then start multu 3×5 → after 32 edges done=1, hi=0, lo=15.
- **Signed multiply:** WIDTH=32, mult a=0xFFFFFFFE (−2), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFF2, done a single-cycle pulse exactly 32 edges after accept. Same operands with multu → hi=0x00000006, lo=0xFFFFFFF2.
- **Signed divide:** div a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). divu a=100, b=7 → lo=14, hi=2, dz=0.
- **Edge divides:** div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, dz=0. divu a=123, b=0 → lo=0xFFFFFFFF, hi=123, dz=1. Next multu 1×1 → dz returns to 0.
- **Handshake:**
  - start pulsed while busy → ignored; the first op's result is unchanged and no extra done appears.
  - start in the done cycle → second done exactly 33 cycles after the first.
  - cancel at edge E10 → busy=0 next cycle, no done, hi/lo keep prior values; cancel+start together in IDLE → no launch.
- **Width sweep:** WIDTH=8, mult a=0x80, b=0x80 → hi=0x40, lo=0x00 after 8 edges. 200 random ops per op code at WIDTH=8 and 32, checked against a behavioural reference model.
